// File: rtl/fetch_predecode_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_predecode_queue_pkg
// Purpose  : Shared system definitions for the fetch predecode queue:
//            predecode control struct, opcode constants and width defaults.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fetch_predecode_queue_pkg;

    localparam int FETCH_WIDTH_DEFAULT    = 2;
    localparam int DISPATCH_WIDTH_DEFAULT = 2;
    localparam int DEPTH_DEFAULT          = 8;

    // Opcode field is inst[31:26]
    localparam logic [5:0]  JSR_GRP  = 6'h1a;
    localparam logic [5:0]  BR_INST  = 6'h30;
    localparam logic [5:0]  BSR_INST = 6'h34;
    localparam logic [5:0]  STQ_INST = 6'h2d;
    // PAL opcode 0x00 with the halt function code; compared against the whole word
    localparam logic [31:0] PAL_HALT = 32'h0000_0555;

    typedef struct packed {
        logic halt;
        logic cond_branch;
        logic uncond_branch;
        logic branch;
        logic wr_mem;
    } FD_control_t;

    // Opcode groups 0x30 and 0x38 together cover every opcode with the top two bits set
    function automatic logic is_branch_group(input logic [5:0] opcode);
        return (opcode[5:4] == 2'b11);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fd_predecode.sv
`default_nettype none
// ============================================================================
// Module   : fd_predecode
// Purpose  : Single-lane combinational instruction predecoder.
// Ports    : i_inst  - raw 32-bit instruction
//            o_ctrl  - predecoded control flags (FD_control_t)
// Revision : 1.0 - initial release
// ============================================================================
module fd_predecode
    import fetch_predecode_queue_pkg::*;
(
    input  logic [31:0] i_inst,
    output FD_control_t o_ctrl
);

    logic [5:0] w_opcode;
    logic       w_br_group;
    logic       w_br_or_bsr;

    assign w_opcode    = i_inst[31:26];
    assign w_br_group  = is_branch_group(w_opcode);
    assign w_br_or_bsr = (w_opcode == BR_INST) || (w_opcode == BSR_INST);

    always_comb begin
        o_ctrl               = '0;
        o_ctrl.uncond_branch = (w_opcode == JSR_GRP) || (w_br_group && w_br_or_bsr);
        // Everything else in the branch groups is a conditional branch
        o_ctrl.cond_branch   = w_br_group && !w_br_or_bsr;
        o_ctrl.wr_mem        = (w_opcode == STQ_INST);
        o_ctrl.halt          = (i_inst == PAL_HALT);
        o_ctrl.branch        = o_ctrl.cond_branch || o_ctrl.uncond_branch;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_predecode_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_predecode_queue
// Purpose  : Predecodes up to FETCH_WIDTH instructions per cycle and buffers
//            instruction, NPC and predecode in an in-order circular queue,
//            offering up to DISPATCH_WIDTH head entries to dispatch.
// Ports    : clock, reset          - clock, synchronous active-high reset
//            if_valid/inst/npc     - fetch group (lanes contiguous from 0)
//            if_accept             - group enqueued this cycle (comb)
//            fq_free               - registered free-entry count
//            fq_valid/inst/npc/ctrl- head entries offered to dispatch
//            dis_count             - entries consumed by dispatch this cycle
//            flush                 - squash all entries, clear halt lock
//            halted                - a halt has been enqueued
// Revision : 1.0 - initial release
// ============================================================================
module fetch_predecode_queue
    import fetch_predecode_queue_pkg::*;
#(
    parameter int FETCH_WIDTH    = FETCH_WIDTH_DEFAULT,
    parameter int DISPATCH_WIDTH = DISPATCH_WIDTH_DEFAULT,
    parameter int DEPTH          = DEPTH_DEFAULT,
    parameter int CNT_W          = $clog2(DEPTH + 1)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [FETCH_WIDTH-1:0]              if_valid,
    input  logic [FETCH_WIDTH-1:0][31:0]        if_inst,
    input  logic [FETCH_WIDTH-1:0][63:0]        if_npc,
    output logic                                if_accept,
    output logic [CNT_W-1:0]                    fq_free,
    output logic [DISPATCH_WIDTH-1:0]           fq_valid,
    output logic [DISPATCH_WIDTH-1:0][31:0]     fq_inst,
    output logic [DISPATCH_WIDTH-1:0][63:0]     fq_npc,
    output FD_control_t [DISPATCH_WIDTH-1:0]    fq_ctrl,
    input  logic [CNT_W-1:0]                    dis_count,
    input  logic                                flush,
    output logic                                halted
);

    localparam int               PTR_W       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_depth_cnt = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // Per-lane predecode
    // ------------------------------------------------------------------
    FD_control_t [FETCH_WIDTH-1:0] w_lane_ctrl;

    generate
        for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_predecode
            fd_predecode u_fd_predecode (
                .i_inst (if_inst[i]),
                .o_ctrl (w_lane_ctrl[i])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Queue state
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_free;
    logic             r_halted;

    logic [31:0]      r_inst_mem [DEPTH];
    logic [63:0]      r_npc_mem  [DEPTH];
    FD_control_t      r_ctrl_mem [DEPTH];

    // ------------------------------------------------------------------
    // Enqueue lane selection: admission is decided on the full group size,
    // but lanes after the first halt are never written.
    // ------------------------------------------------------------------
    logic [FETCH_WIDTH-1:0] w_wr_en;
    logic [CNT_W-1:0]       w_n_in;
    logic [CNT_W-1:0]       w_n_enq;
    logic                   w_halt_enq;

    always_comb begin
        w_wr_en    = '0;
        w_n_in     = '0;
        w_n_enq    = '0;
        w_halt_enq = 1'b0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            w_n_in = w_n_in + CNT_W'(if_valid[i]);
            if (if_valid[i] && !w_halt_enq) begin
                w_wr_en[i] = 1'b1;
                w_n_enq    = w_n_enq + CNT_W'(1);
                if (w_lane_ctrl[i].halt) begin
                    w_halt_enq = 1'b1;
                end
            end
        end
    end

    // Space check uses the registered free count only, so a same-cycle
    // dequeue never makes room for the incoming group.
    assign if_accept = !flush && !r_halted && (w_n_in != '0) && (w_n_in <= r_free);

    logic [CNT_W-1:0] w_count_next;
    assign w_count_next = r_count + (if_accept ? w_n_enq : '0) - dis_count;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_free   <= c_depth_cnt;
            r_halted <= 1'b0;
        end else begin
            r_head  <= r_head + PTR_W'(dis_count);
            if (if_accept) begin
                r_tail <= r_tail + PTR_W'(w_n_enq);
            end
            r_count <= w_count_next;
            r_free  <= c_depth_cnt - w_count_next;
            if (if_accept && w_halt_enq) begin
                r_halted <= 1'b1;
            end
        end
    end

    // Storage holds no reset; validity is tracked purely by r_count.
    always_ff @(posedge clock) begin
        if (if_accept) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (w_wr_en[i]) begin
                    r_inst_mem[r_tail + PTR_W'(i)] <= if_inst[i];
                    r_npc_mem[r_tail + PTR_W'(i)]  <= if_npc[i];
                    r_ctrl_mem[r_tail + PTR_W'(i)] <= w_lane_ctrl[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Dispatch view of the head entries
    // ------------------------------------------------------------------
    generate
        for (genvar j = 0; j < DISPATCH_WIDTH; j++) begin : g_dispatch
            logic [PTR_W-1:0] w_rd_idx;
            assign w_rd_idx    = r_head + PTR_W'(j);
            assign fq_valid[j] = (CNT_W'(j) < r_count);
            assign fq_inst[j]  = r_inst_mem[w_rd_idx];
            assign fq_npc[j]   = r_npc_mem[w_rd_idx];
            assign fq_ctrl[j]  = r_ctrl_mem[w_rd_idx];
        end
    endgenerate

    assign fq_free = r_free;
    assign halted  = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_predecode_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_predecode_queue
// Purpose  : Self-checking bench for fetch_predecode_queue (2 lanes, depth 8).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_predecode_queue;
    import fetch_predecode_queue_pkg::*;

    localparam int CNT_W = 4;

    localparam logic [31:0] I_ADDQ = 32'h4022_0403;
    localparam logic [31:0] I_BR   = 32'hC3E0_0004;
    localparam logic [31:0] I_BSR  = 32'hD340_0010;
    localparam logic [31:0] I_JSR  = 32'h6B5A_4000;
    localparam logic [31:0] I_BEQ  = 32'hE420_0008;
    localparam logic [31:0] I_BGT  = 32'hFC20_0008;
    localparam logic [31:0] I_BLBC = 32'hE020_0002;
    localparam logic [31:0] I_STQ  = 32'hB43E_0008;
    localparam logic [31:0] I_STL  = 32'hB03E_0008;
    localparam logic [31:0] I_LDQ  = 32'hA43E_0008;
    localparam logic [31:0] I_HALT = 32'h0000_0555;
    localparam logic [31:0] I_CSYS = 32'h0000_0083;

    logic                    clock;
    logic                    reset;
    logic [1:0]              if_valid;
    logic [1:0][31:0]        if_inst;
    logic [1:0][63:0]        if_npc;
    logic                    if_accept;
    logic [CNT_W-1:0]        fq_free;
    logic [1:0]              fq_valid;
    logic [1:0][31:0]        fq_inst;
    logic [1:0][63:0]        fq_npc;
    FD_control_t [1:0]       fq_ctrl;
    logic [CNT_W-1:0]        dis_count;
    logic                    flush;
    logic                    halted;

    fetch_predecode_queue #(
        .FETCH_WIDTH    (2),
        .DISPATCH_WIDTH (2),
        .DEPTH          (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .if_valid  (if_valid),
        .if_inst   (if_inst),
        .if_npc    (if_npc),
        .if_accept (if_accept),
        .fq_free   (fq_free),
        .fq_valid  (fq_valid),
        .fq_inst   (fq_inst),
        .fq_npc    (fq_npc),
        .fq_ctrl   (fq_ctrl),
        .dis_count (dis_count),
        .flush     (flush),
        .halted    (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Dispatch must never consume more than is offered
    always @(posedge clock) begin
        if (!reset) begin
            assert (dis_count <= CNT_W'(fq_valid[0]) + CNT_W'(fq_valid[1]))
                else $error("dis_count %0d exceeds offered entries %b", dis_count, fq_valid);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                          input logic [63:0] n0, input logic [63:0] n1,
                          input logic [CNT_W-1:0] d, input logic fl);
        if_valid   = v;
        if_inst[0] = i0;
        if_inst[1] = i1;
        if_npc[0]  = n0;
        if_npc[1]  = n1;
        dis_count  = d;
        flush      = fl;
    endtask

    task automatic idle();
        set_in(2'b00, 32'h0, 32'h0, 64'h0, 64'h0, '0, 1'b0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Golden model of the original single-lane fetch decoder
    function automatic logic [4:0] golden(input logic [31:0] inst);
        logic [5:0] op;
        logic h, c, u, w;
        op = inst[31:26];
        h  = (inst == 32'h0000_0555);
        w  = (op == 6'h2d);
        c  = 1'b0;
        u  = 1'b0;
        case ({op[5:3], 3'b000})
            6'h18: u = (op == 6'h1a);
            6'h30, 6'h38: begin
                if (op == 6'h30 || op == 6'h34) u = 1'b1;
                else                            c = 1'b1;
            end
            default: ;
        endcase
        return {h, c, u, (u | c), w};
    endfunction

    function automatic logic [31:0] winst(input int k);
        return 32'h4000_0000 + 32'(k);
    endfunction

    function automatic logic [63:0] wnpc(input int k);
        return 64'h2000 + 64'(4 * (k + 1));
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  exp_ctrl;   // {halt, cond, uncond, branch, wr_mem}
    } vec_t;

    vec_t vecs[12];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int         issued;
    int         mcount;
    int         cyc;
    int         n;
    logic [1:0] v;
    logic [CNT_W-1:0] d;
    logic       exp_acc;
    logic [31:0] sb_i[$];
    logic [63:0] sb_n[$];

    initial begin
        vecs[0]  = '{I_ADDQ, 5'b00000};
        vecs[1]  = '{I_BR,   5'b00110};
        vecs[2]  = '{I_BSR,  5'b00110};
        vecs[3]  = '{I_JSR,  5'b00110};
        vecs[4]  = '{I_BEQ,  5'b01010};
        vecs[5]  = '{I_BGT,  5'b01010};
        vecs[6]  = '{I_BLBC, 5'b01010};
        vecs[7]  = '{I_STQ,  5'b00001};
        vecs[8]  = '{I_STL,  5'b00000};
        vecs[9]  = '{I_LDQ,  5'b00000};
        vecs[10] = '{I_HALT, 5'b10000};
        vecs[11] = '{I_CSYS, 5'b00000};

        // ---------------- reset ----------------
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_free", fq_free, 8);
        chk("rst_valid", fq_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_accept", if_accept, 0);

        // ---------------- basic group {ADDQ, BR} ----------------
        set_in(2'b11, I_ADDQ, I_BR, 64'h4, 64'h8, '0, 1'b0);
        #1;
        chk("t1_accept", if_accept, 1);
        step();
        idle();
        #1;
        chk("t1_valid", fq_valid, 2'b11);
        chk("t1_inst0", fq_inst[0], I_ADDQ);
        chk("t1_inst1", fq_inst[1], I_BR);
        chk("t1_npc0", fq_npc[0], 64'h4);
        chk("t1_npc1", fq_npc[1], 64'h8);
        chk("t1_ctrl0", fq_ctrl[0], 5'b00000);
        chk("t1_ctrl1", fq_ctrl[1], 5'b00110);
        chk("t1_free", fq_free, 6);
        set_in(2'b00, 32'h0, 32'h0, 64'h0, 64'h0, 4'd2, 1'b0);
        step();
        idle();
        #1;
        chk("t1_drain_free", fq_free, 8);
        chk("t1_drain_valid", fq_valid, 0);

        // ---------------- fill to full ----------------
        for (int g = 0; g < 4; g++) begin
            set_in(2'b11, winst(2*g), winst(2*g+1), wnpc(2*g), wnpc(2*g+1), '0, 1'b0);
            #1;
            chk("fill_accept", if_accept, 1);
            step();
        end
        set_in(2'b11, winst(8), winst(9), wnpc(8), wnpc(9), '0, 1'b0);
        #1;
        chk("full_free", fq_free, 0);
        chk("full_reject", if_accept, 0);
        step();
        set_in(2'b11, winst(8), winst(9), wnpc(8), wnpc(9), 4'd2, 1'b0);
        #1;
        chk("full_deq_reject", if_accept, 0);
        chk("full_head", fq_inst[0], winst(0));
        step();
        set_in(2'b11, winst(8), winst(9), wnpc(8), wnpc(9), '0, 1'b0);
        #1;
        chk("after_deq_free", fq_free, 2);
        chk("after_deq_accept", if_accept, 1);
        chk("after_deq_head", fq_inst[0], winst(2));
        chk("after_deq_npc", fq_npc[1], wnpc(3));
        step();
        set_in(2'b00, 32'h0, 32'h0, 64'h0, 64'h0, '0, 1'b1);
        #1;
        chk("refill_free", fq_free, 0);
        step();
        idle();
        #1;
        chk("fill_flush_free", fq_free, 8);
        chk("fill_flush_valid", fq_valid, 0);

        // ---------------- halt lock ----------------
        set_in(2'b11, I_HALT, I_STQ, 64'h40, 64'h44, '0, 1'b0);
        #1;
        chk("halt_accept", if_accept, 1);
        step();
        set_in(2'b11, I_ADDQ, I_ADDQ, 64'h48, 64'h4c, '0, 1'b0);
        #1;
        chk("halt_set", halted, 1);
        chk("halt_valid", fq_valid, 2'b01);
        chk("halt_inst", fq_inst[0], I_HALT);
        chk("halt_ctrl", fq_ctrl[0], 5'b10000);
        chk("halt_free", fq_free, 7);
        chk("halt_block", if_accept, 0);
        step();
        set_in(2'b00, 32'h0, 32'h0, 64'h0, 64'h0, '0, 1'b1);
        #1;
        chk("halt_block_free", fq_free, 7);
        step();
        set_in(2'b11, I_ADDQ, I_HALT, 64'h50, 64'h54, '0, 1'b0);
        #1;
        chk("halt_clr", halted, 0);
        chk("halt_clr_valid", fq_valid, 0);
        chk("halt_l1_accept", if_accept, 1);
        step();
        set_in(2'b00, 32'h0, 32'h0, 64'h0, 64'h0, '0, 1'b1);
        #1;
        chk("halt_l1_free", fq_free, 6);
        chk("halt_l1_set", halted, 1);
        chk("halt_l1_ctrl", fq_ctrl[1], 5'b10000);
        step();

        // ---------------- flush beats enqueue/dequeue ----------------
        set_in(2'b11, I_ADDQ, I_BR, 64'h60, 64'h64, '0, 1'b0);
        #1;
        chk("fl_pre_accept", if_accept, 1);
        step();
        set_in(2'b11, I_BEQ, I_STQ, 64'h68, 64'h6c, 4'd2, 1'b1);
        #1;
        chk("fl_accept", if_accept, 0);
        step();
        idle();
        #1;
        chk("fl_free", fq_free, 8);
        chk("fl_valid", fq_valid, 0);
        step();
        chk("fl_valid_hold", fq_valid, 0);

        // ---------------- reset mid-operation ----------------
        set_in(2'b11, I_ADDQ, I_BR, 64'h70, 64'h74, '0, 1'b0);
        step();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("mrst_free", fq_free, 8);
        chk("mrst_valid", fq_valid, 0);

        // ---------------- stream with pointer wrap ----------------
        issued = 0;
        mcount = 0;
        cyc    = 0;
        while ((issued < 20 || mcount > 0) && cyc < 200) begin
            n = (20 - issued >= 2) ? 2 : (20 - issued);
            v = (n == 2) ? 2'b11 : ((n == 1) ? 2'b01 : 2'b00);
            d = (mcount > 0) ? 4'd1 : 4'd0;
            set_in(v, winst(issued), winst(issued + 1), wnpc(issued), wnpc(issued + 1), d, 1'b0);
            #1;
            exp_acc = (n != 0) && (n <= 8 - mcount);
            chk("wrap_accept", if_accept, exp_acc);
            chk("wrap_valid", fq_valid, (mcount >= 2) ? 2'b11 : ((mcount == 1) ? 2'b01 : 2'b00));
            if (mcount > 0) begin
                chk("wrap_inst0", fq_inst[0], sb_i[0]);
                chk("wrap_npc0", fq_npc[0], sb_n[0]);
            end
            if (mcount > 1) begin
                chk("wrap_inst1", fq_inst[1], sb_i[1]);
            end
            step();
            if (d != 0) begin
                void'(sb_i.pop_front());
                void'(sb_n.pop_front());
                mcount--;
            end
            if (exp_acc) begin
                for (int k = 0; k < n; k++) begin
                    sb_i.push_back(winst(issued + k));
                    sb_n.push_back(wnpc(issued + k));
                end
                issued += n;
                mcount += n;
            end
            cyc++;
        end
        if (issued < 20 || mcount > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL wrap_timeout: issued %0d outstanding %0d", issued, mcount);
        end
        idle();
        #1;
        chk("wrap_end_free", fq_free, 8);

        // ---------------- predecode table, lane 1 ----------------
        for (int t = 0; t < 12; t++) begin
            set_in(2'b11, I_ADDQ, vecs[t].inst, 64'h80, 64'h84, '0, 1'b0);
            #1;
            chk("pd_accept", if_accept, 1);
            step();
            set_in(2'b00, 32'h0, 32'h0, 64'h0, 64'h0, '0, 1'b1);
            #1;
            chk($sformatf("pd_ctrl_%08h", vecs[t].inst), fq_ctrl[1], vecs[t].exp_ctrl);
            chk("pd_ctrl0", fq_ctrl[0], 5'b00000);
            step();
        end

        // ---------------- full opcode sweep, lane 1 ----------------
        for (int op = 0; op < 64; op++) begin
            logic [31:0] sw;
            sw = {6'(op), 26'h000_0555};
            set_in(2'b11, I_ADDQ, sw, 64'h90, 64'h94, '0, 1'b0);
            step();
            set_in(2'b00, 32'h0, 32'h0, 64'h0, 64'h0, '0, 1'b1);
            #1;
            chk($sformatf("sweep_op_%02h", op), fq_ctrl[1], golden(sw));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
